// File: rtl/imem_boot_loader_if.sv
// Byte-stream receive and instruction-memory write port bundle for the boot loader.
interface imem_boot_loader_if #(
  parameter int N = 10,
  parameter int M = 32
);
  logic         rx_valid;
  logic [7:0]   rx_data;
  logic         rx_ready;
  logic         imem_we;
  logic [N-1:0] imem_addr;
  logic [M-1:0] imem_wdata;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot sequencer: holds the core in reset, receives a length-prefixed little-endian
// program over a byte handshake, writes it to instruction memory, then releases the core.
module imem_boot_loader #(
  parameter int N = 10,
  parameter int M = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  imem_boot_loader_if.slave    bus,
  output logic                 core_rst_n,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam logic [31:0] CAP = 32'(1) << N;

  state_t      state;
  logic [15:0] count;
  logic [N:0]  idx;
  logic [1:0]  lane;
  logic [23:0] shbuf;

  logic        accept;
  logic [15:0] hdr;
  logic [N:0]  idx_next;

  assign accept   = bus.rx_valid & bus.rx_ready;
  assign hdr      = {bus.rx_data, count[7:0]};
  assign idx_next = idx + (N+1)'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      count          <= '0;
      idx            <= '0;
      lane           <= '0;
      shbuf          <= '0;
      core_rst_n     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      bus.rx_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state        <= HDR0;
            core_rst_n   <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            idx          <= '0;
            lane         <= '0;
            busy         <= 1'b1;
            bus.rx_ready <= 1'b1;
          end
        end

        HDR0: begin
          if (accept) begin
            count[7:0] <= bus.rx_data;
            state      <= HDR1;
          end
        end

        HDR1: begin
          if (accept) begin
            count[15:8] <= bus.rx_data;
            if (hdr == 16'd0) begin
              state        <= DONE;
              done         <= 1'b1;
              core_rst_n   <= 1'b1;
              busy         <= 1'b0;
              bus.rx_ready <= 1'b0;
            end else if ({16'd0, hdr} > CAP) begin
              state        <= ERR;
              err          <= 1'b1;
              busy         <= 1'b0;
              bus.rx_ready <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (accept) begin
            lane <= lane + 2'd1;
            // The fourth byte bypasses the buffer straight into the registered write word.
            if (lane == 2'd3) begin
              state          <= WRITE;
              bus.rx_ready   <= 1'b0;
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= idx[N-1:0];
              bus.imem_wdata <= {bus.rx_data, shbuf};
            end else begin
              shbuf[{lane, 3'b000} +: 8] <= bus.rx_data;
            end
          end
        end

        WRITE: begin
          idx  <= idx_next;
          lane <= '0;
          if (32'(idx_next) == {16'd0, count}) begin
            state        <= DONE;
            done         <= 1'b1;
            core_rst_n   <= 1'b1;
            busy         <= 1'b0;
            bus.rx_ready <= 1'b0;
          end else begin
            state        <= DATA;
            bus.rx_ready <= 1'b1;
          end
        end

        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          bus.rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized self-checking bench for imem_boot_loader against a write-list reference model.
module tb_imem_boot_loader;
  localparam int N = 10;
  localparam int CAPW = 1 << N;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic core_rst_n, busy, done, err;
  int   cyc = 0;

  imem_boot_loader_if #(.N(N), .M(32)) bus();

  imem_boot_loader #(.N(N), .M(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic [31:0]  d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] wq[$];

  // Every write pulse must match the next expected (address, word) pair with the core held.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_we", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.imem_addr), 32'(e.a));
        chk("wr_data", bus.imem_wdata, e.d);
        chk("wr_core_held", 32'(core_rst_n), 32'd0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gapmax);
    int g;
    g = $urandom_range(gapmax, 0);
    repeat (g) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    for (int i = 0; i < 50; i++) begin
      if (bus.rx_ready === 1'b1) begin
        @(negedge clk);
        bus.rx_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    chk("rx_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_load(input logic [15:0] cnt, input int gapmax, input bit inject);
    int          t0;
    logic [31:0] w;
    pulse_start();
    t0 = cyc;
    chk("hdr_ready", 32'(bus.rx_ready), 32'd1);
    chk("hdr_busy", 32'(busy), 32'd1);
    chk("hdr_core", 32'(core_rst_n), 32'd0);
    chk("hdr_flags", 32'({done, err}), 32'd0);

    if (cnt != 0 && int'(cnt) <= CAPW)
      for (int i = 0; i < int'(cnt); i++) begin
        wr_t e;
        e.a = N'(i);
        e.d = wq[i];
        exp_q.push_back(e);
      end

    send_byte(cnt[7:0], gapmax);
    send_byte(cnt[15:8], gapmax);

    if (cnt == 0) begin
      chk("empty_done", 32'(done), 32'd1);
      chk("empty_core", 32'(core_rst_n), 32'd1);
      chk("empty_idle", 32'({busy, err, bus.rx_ready, bus.imem_we}), 32'd0);
    end else if (int'(cnt) > CAPW) begin
      chk("ovf_err", 32'(err), 32'd1);
      chk("ovf_done", 32'(done), 32'd0);
      chk("ovf_core", 32'(core_rst_n), 32'd0);
      chk("ovf_idle", 32'({busy, bus.rx_ready}), 32'd0);
      repeat (3) @(negedge clk);
      chk("ovf_sticky", 32'({err, core_rst_n}), 32'b10);
    end else begin
      for (int i = 0; i < int'(cnt); i++) begin
        w = wq[i];
        for (int k = 0; k < 4; k++) begin
          if (inject && i == 0 && k == 2) begin
            pulse_start();
            chk("inject_busy", 32'(busy), 32'd1);
          end
          send_byte(w[8*k +: 8], gapmax);
        end
      end
      chk("last_we", 32'(bus.imem_we), 32'd1);
      chk("last_not_done", 32'(done), 32'd0);
      @(negedge clk);
      chk("load_done", 32'(done), 32'd1);
      chk("load_core", 32'(core_rst_n), 32'd1);
      chk("load_idle", 32'({busy, err, bus.rx_ready}), 32'd0);
      chk("writes_left", 32'(exp_q.size()), 32'd0);
      if (gapmax == 0 && !inject)
        chk("load_time", 32'(cyc - t0), 32'(2 + 5 * int'(cnt)));
    end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", 32'({core_rst_n, bus.rx_ready, busy, done, err, bus.imem_we}), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);
    chk("rst_wdata", bus.imem_wdata, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      bus.rx_valid = 1'($urandom);
      bus.rx_data  = 8'($urandom);
      @(negedge clk);
      chk("idle_outputs", 32'({core_rst_n, bus.rx_ready, busy, done, err, bus.imem_we}), 32'd0);
    end
    bus.rx_valid = 1'b0;

    wq = '{32'h00A00513, 32'h00B00593};
    do_load(16'd2, 0, 1'b0);

    do_load(16'd0, 0, 1'b0);

    do_load(16'd1025, 0, 1'b0);
    wq = '{$urandom};
    do_load(16'd1, 2, 1'b0);

    wq = '{32'h00A00513, 32'h00B00593};
    do_load(16'd2, 5, 1'b1);

    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    #2 rst = 1'b0;
    #1;
    chk("midrst_outputs", 32'({core_rst_n, bus.rx_ready, busy, done, err, bus.imem_we}), 32'd0);
    chk("midrst_addr", 32'(bus.imem_addr), 32'd0);
    chk("midrst_wdata", bus.imem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    wq = '{$urandom};
    do_load(16'd1, 3, 1'b0);

    repeat (4) begin
      int c;
      c = $urandom_range(5, 1);
      wq.delete();
      for (int i = 0; i < c; i++) wq.push_back($urandom);
      do_load(16'(c), 3, 1'b0);
    end

    do_load(16'hFFFF, 1, 1'b0);

    wq.delete();
    for (int i = 0; i < CAPW; i++) wq.push_back($urandom);
    do_load(16'(CAPW), 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
